// File: rtl/bitstream_load_ctrl_pkg.sv
// Shared definitions for the bitstream load controller and its users.
//   state_e        : controller state encoding (IDLE=0 .. ERROR=5)
//   *_DEF          : default chain length, checksum width and CRC polynomial
//   is_busy()      : true in the states where a load is in progress
package bitstream_load_ctrl_pkg;

  localparam int unsigned       CHAIN_LEN_DEF = 64;
  localparam int unsigned       CS_W_DEF      = 8;
  localparam logic [CS_W_DEF-1:0] CS_POLY_DEF = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  function automatic logic is_busy(input state_e s);
    return s inside {ST_CLEAR, ST_LOAD, ST_CHECK};
  endfunction

endpackage

// File: rtl/crc_serial.sv
// Bit-serial CRC, MSB-first, init 0, no final XOR. Shared by the load
// controller and the PMU checksum path.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : fold bit_in into the CRC this cycle
//   bit_in     : serial data bit
//   crc        : current CRC value
module crc_serial #(
  parameter int unsigned       CS_W    = 8,
  parameter logic [CS_W-1:0]   CS_POLY = 8'h07
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            bit_in,
  output logic [CS_W-1:0] crc
);

  logic feedback;

  assign feedback = crc[CS_W-1] ^ bit_in;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CS_W-2:0], 1'b0} ^ (feedback ? CS_POLY : '0);
    end
  end

endmodule

// File: rtl/bitstream_load_ctrl.sv
// Sequences one serial bitstream load into the configuration chain.
// Forwards CHAIN_LEN bits, optionally checks a trailing CRC, then releases
// the fabric reset on success or holds it on failure/abort.
//   tck_i         : TAP clock
//   rst_ni        : async active-low reset
//   start_i       : 1-cycle pulse, begin a load (ignored while busy or with abort_i)
//   cs_en_i       : checksum mode, sampled on an accepted start_i
//   bit_valid_i   : serial bit present this cycle
//   bit_i         : serial bit
//   abort_i       : shift path left before the load completed
//   chain_data_o  : bit to the config chain
//   chain_shift_o : 1-cycle shift enable to the config chain
//   chain_rst_o   : active-high fabric/chain reset
//   busy_o        : high in CLEAR/LOAD/CHECK
//   done_o        : load succeeded (held until the next start)
//   err_o         : checksum failure or abort (held until the next start)
//   bit_cnt_o     : bits accepted in the current load
module bitstream_load_ctrl
  import bitstream_load_ctrl_pkg::*;
#(
  parameter int unsigned       CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned       CS_W      = CS_W_DEF,
  parameter logic [CS_W-1:0]   CS_POLY   = CS_POLY_DEF,
  parameter int unsigned       CNT_W     = $clog2(CHAIN_LEN + CS_W + 1)
) (
  input  logic             tck_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cs_en_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             abort_i,
  output logic             chain_data_o,
  output logic             chain_shift_o,
  output logic             chain_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] bit_cnt_o
);

  // Count values of the bit that completes the data / checksum phase.
  localparam logic [CNT_W-1:0] DATA_END = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CS_LAST   = CNT_W'(CHAIN_LEN + CS_W - 1);

  state_e          state_q, state_d;
  logic            cs_mode_q;
  logic [CS_W-1:0] rx_cs_q;
  logic [CS_W-1:0] crc;
  logic            start_ok;  // start accepted this cycle
  logic            bit_ok;    // bit accepted (counted) this cycle
  logic            fwd_bit;   // accepted bit belongs to the data phase
  logic            cs_bit;    // accepted bit belongs to the checksum phase

  crc_serial #(
    .CS_W    (CS_W),
    .CS_POLY (CS_POLY)
  ) u_crc (
    .clk    (tck_i),
    .rst_n  (rst_ni),
    .clr    (start_ok),
    .en     (fwd_bit),
    .bit_in (bit_i),
    .crc    (crc)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    bit_ok   = 1'b0;
    fwd_bit  = 1'b0;
    cs_bit   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // abort_i outranks a simultaneous start_i.
        if (start_i && !abort_i) begin
          start_ok = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = abort_i ? ST_ERROR : ST_LOAD;
      ST_LOAD: begin
        if (abort_i) begin
          state_d = ST_ERROR;
        end else if (bit_valid_i) begin
          bit_ok = 1'b1;
          if (bit_cnt_o < DATA_END) fwd_bit = 1'b1;
          else                      cs_bit  = 1'b1;
          // The completing bit is still forwarded/captured this cycle.
          if (!cs_mode_q && bit_cnt_o == DATA_LAST)    state_d = ST_DONE;
          else if (cs_mode_q && bit_cnt_o == CS_LAST)  state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort_i)             state_d = ST_ERROR;
        else if (rx_cs_q == crc) state_d = ST_DONE;
        else                     state_d = ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register itself.
  // NOTE: rx_cs_q is a small shift register, not a memory array, so it is
  // reset along with the rest of the control state.
  always_ff @(posedge tck_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      cs_mode_q     <= 1'b0;
      rx_cs_q       <= '0;
      bit_cnt_o     <= '0;
      chain_data_o  <= 1'b0;
      chain_shift_o <= 1'b0;
      chain_rst_o   <= 1'b1;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      chain_shift_o <= fwd_bit;
      if (fwd_bit) chain_data_o <= bit_i;

      if (start_ok) begin
        bit_cnt_o <= '0;
        rx_cs_q   <= '0;
        cs_mode_q <= cs_en_i;
      end else if (bit_ok) begin
        bit_cnt_o <= bit_cnt_o + CNT_W'(1);
      end
      if (cs_bit) rx_cs_q <= {rx_cs_q[CS_W-2:0], bit_i};

      busy_o <= is_busy(state_d);
      done_o <= (state_d == ST_DONE);
      err_o  <= (state_d == ST_ERROR);
      // Fabric stays wiped through CLEAR and after a failure; in IDLE the
      // last value is kept.
      if (state_d == ST_CLEAR || state_d == ST_ERROR)     chain_rst_o <= 1'b1;
      else if (state_d == ST_LOAD || state_d == ST_DONE)  chain_rst_o <= 1'b0;
    end
  end

endmodule
